// File: rtl/aes128_key_expand_seq.sv
// aes128_key_expand_seq
//
// Iterative AES-128 key-schedule sequencer. A cipher key is accepted on
// start while idle. The eleven round keys (rounds 0..10) are then presented
// one per accepted transfer. One shared RotWord/SubWord/Rcon datapath derives
// round key r+1 from round key r, so only the current key is stored.
//
// Handshake: a transfer happens on a rising clk edge where rk_valid and
// rk_ready are both high. While rk_valid is high and rk_ready is low,
// round_key and rk_index are held unchanged. rk_valid stays high until round
// key 10 has been accepted. rk_valid does not depend on rk_ready.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   start      request to begin expansion (honoured only when idle)
//   key_in     128-bit cipher key, byte 0 in [127:120], sampled on accepted start
//   busy       high from accepted start until round key 10 is accepted
//   rk_valid   round_key / rk_index are valid
//   rk_ready   downstream accepts the current round key
//   rk_index   round number of round_key, 0..10
//   round_key  {w[4r], w[4r+1], w[4r+2], w[4r+3]}, w[4r] in [127:96]
//   done       combinational pulse in the cycle round key 10 is accepted
module aes128_key_expand_seq #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [3:0]   rk_index,
  output logic [127:0] round_key,
  output logic         done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  localparam logic [3:0] LAST_IDX = 4'(NR);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic [0:0]   state;
  logic [7:0]   rcon;
  logic         transfer;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_w, sub_w, t_w;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] next_key;
  logic [7:0]   rcon_next;

  assign transfer = rk_valid & rk_ready;
  assign done     = transfer & (rk_index == LAST_IDX);

  // Next round key from the current one: t = SubWord(RotWord(w3)) ^ Rcon,
  // then each new word chains off the previous new word.
  always_comb begin
    w0       = round_key[127:96];
    w1       = round_key[95:64];
    w2       = round_key[63:32];
    w3       = round_key[31:0];
    rot_w    = {w3[23:0], w3[31:24]};
    sub_w    = {SBOX[rot_w[31:24]], SBOX[rot_w[23:16]],
                SBOX[rot_w[15:8]],  SBOX[rot_w[7:0]]};
    t_w      = sub_w ^ {rcon, 24'h000000};
    n0       = w0 ^ t_w;
    n1       = w1 ^ n0;
    n2       = w2 ^ n1;
    n3       = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  // xtime in GF(2^8): 01,02,..,80 then wraps to 1B, 36.
  assign rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      rk_valid  <= 1'b0;
      rk_index  <= 4'd0;
      round_key <= 128'h0;
      rcon      <= 8'h01;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            round_key <= key_in;
            rk_index  <= 4'd0;
            rcon      <= 8'h01;
            busy      <= 1'b1;
            rk_valid  <= 1'b1;
            state     <= EMIT;
          end
        end
        EMIT: begin
          // Without a transfer everything holds, which gives stall stability.
          // start is not looked at here, so it cannot restart a sequence.
          if (transfer) begin
            if (rk_index == LAST_IDX) begin
              // Final key accepted: last round_key/rk_index stay visible.
              rk_valid <= 1'b0;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              round_key <= next_key;
              rk_index  <= rk_index + 4'd1;
              rcon      <= rcon_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_key_expand_seq.sv
module tb_aes128_key_expand_seq;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready = 1'b0;
  logic [3:0]   rk_index;
  logic [127:0] round_key;
  logic         done;

  always #5 clk = ~clk;

  aes128_key_expand_seq #(.NR(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .busy      (busy),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_index  (rk_index),
    .round_key (round_key),
    .done      (done)
  );

  localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_RK1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_RK1    = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_RK10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] KEY_ONES = {128{1'b1}};

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  logic [7:0]   sbox_m   [256];
  logic [7:0]   rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [127:0] mk       [11];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox_m[x] = s;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox_m[x[31:24]], sbox_m[x[23:16]], sbox_m[x[15:8]], sbox_m[x[7:0]]};
  endfunction

  // FIPS-197 word-array expansion into mk[0..10].
  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] temp;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0)
        temp = sub_word({temp[23:0], temp[31:24]}) ^ {rcon_tab[i/4 - 1], 24'h0};
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r < 11; r++) mk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- scoreboard ----------------
  logic [131:0] exp_q[$];
  logic [127:0] got_rk [11];
  int busy_cnt, stall_cnt, done_cnt, xfer_cnt;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic clear_counts();
    busy_cnt = 0; stall_cnt = 0; done_cnt = 0; xfer_cnt = 0;
    for (int r = 0; r < 11; r++) got_rk[r] = '0;
  endtask

  // ---------------- ready driver ----------------
  // 0: always ready, 1: random, 2: three stall cycles at index 4 then random
  int ready_mode  = 0;
  int stalls_left = 0;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: rk_ready = 1'b1;
      1: rk_ready = 1'($urandom_range(0, 1));
      2: begin
        if (rk_valid && rk_index == 4'd4 && stalls_left > 0) begin
          rk_ready = 1'b0;
          stalls_left--;
        end else if (stalls_left > 0) rk_ready = 1'b1;
        else rk_ready = 1'($urandom_range(0, 1));
      end
      default: rk_ready = 1'b0;
    endcase
  end

  // ---------------- monitor ----------------
  logic         prev_stall = 1'b0;
  logic [127:0] prev_key;
  logic [3:0]   prev_idx;

  always @(negedge clk) begin
    logic [131:0] e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (prev_stall) begin
        check("stall_valid", rk_valid, 1'b1);
        check("stall_key", round_key, prev_key);
        check("stall_index", rk_index, prev_idx);
      end
      if (rk_valid && rk_index < 4'd10)
        check("rcon", dut.rcon, rcon_tab[rk_index]);
      if (rk_valid && rk_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_xfer: got index %0d required no transfer", rk_index);
        end else begin
          e = exp_q.pop_front();
          check("rk_index", rk_index, e[131:128]);
          check("round_key", round_key, e[127:0]);
          check("done_on_xfer", done, e[131:128] == 4'd10);
        end
        if (rk_index <= 4'd10) got_rk[rk_index] = round_key;
        if (done) done_cnt++;
      end else begin
        if (rk_valid) stall_cnt++;
        check("done_no_xfer", done, 1'b0);
      end
      prev_stall = rk_valid & ~rk_ready;
      prev_key   = round_key;
      prev_idx   = rk_index;
    end
  end

  // ---------------- stimulus tasks ----------------
  // Called at posedge+1 while the DUT is idle; pushes the expected keys.
  task automatic start_seq(input logic [127:0] k);
    model_expand(k);
    for (int r = 0; r < 11; r++) exp_q.push_back({4'(r), mk[r]});
    start  = 1'b1;
    key_in = k;
    @(posedge clk); #1;
    start  = 1'b0;
    key_in = '0;
  endtask

  task automatic pulse_start(input logic [127:0] k);
    start  = 1'b1;
    key_in = k;
    @(posedge clk); #1;
    start  = 1'b0;
    key_in = '0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(exp_q.size() == 0 && !busy) && n < budget) begin
      @(posedge clk); #1; n++;
    end
    check("idle_timeout", n >= budget, 1'b0);
  endtask

  task automatic wait_index(input logic [3:0] idx, input int budget);
    int n = 0;
    while (!(rk_valid && rk_index == idx) && n < budget) begin
      @(posedge clk); #1; n++;
    end
    check("index_timeout", n >= budget, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    build_sbox();
    rst = 1'b1; start = 1'b0; key_in = '0; ready_mode = 0;
    clear_counts();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_valid", rk_valid, 1'b0);
    check("rst_index", rk_index, 4'd0);
    check("rst_key", round_key, 128'h0);
    check("rst_done", done, 1'b0);
    check("rst_rcon", dut.rcon, 8'h01);
    @(posedge clk); #1;

    // FIPS-197 A.1 key with ready held high
    clear_counts();
    start_seq(KEY_A1);
    check("a1_latency_valid", rk_valid, 1'b1);
    wait_idle(50);
    check("a1_rk0", got_rk[0], KEY_A1);
    check("a1_rk1", got_rk[1], A1_RK1);
    check("a1_rk10", got_rk[10], A1_RK10);
    check("a1_done_cnt", done_cnt, 1);
    check("a1_busy_cycles", busy_cnt, 11);
    check("a1_xfers", xfer_cnt, 11);
    check("a1_hold_index", rk_index, 4'd10);
    check("a1_hold_key", round_key, A1_RK10);

    // all-zero key
    clear_counts();
    start_seq('0);
    wait_idle(50);
    check("zero_rk1", got_rk[1], Z_RK1);
    check("zero_rk10", got_rk[10], Z_RK10);
    check("zero_done_cnt", done_cnt, 1);

    // backpressure: 3 stalls at index 4, then random ready
    clear_counts();
    stalls_left = 3;
    ready_mode  = 2;
    start_seq(KEY_A1);
    wait_idle(400);
    check("bp_xfers", xfer_cnt, 11);
    check("bp_min_stalls", stall_cnt >= 3, 1'b1);
    check("bp_busy_cycles", busy_cnt, 11 + stall_cnt);
    check("bp_rk10", got_rk[10], A1_RK10);
    check("bp_done_cnt", done_cnt, 1);

    // starts while busy and in the done cycle are ignored
    ready_mode = 0;
    @(posedge clk); #1;
    clear_counts();
    start_seq(KEY_A1);
    wait_index(4'd5, 20);
    pulse_start(KEY_ONES);
    wait_index(4'd10, 20);
    check("ign_done_now", done, 1'b1);
    pulse_start(KEY_ONES);
    check("ign_idle_busy", busy, 1'b0);
    check("ign_idle_valid", rk_valid, 1'b0);
    check("ign_rk10", got_rk[10], A1_RK10);
    check("ign_done_cnt", done_cnt, 1);
    check("ign_q_empty", exp_q.size(), 0);
    // start one cycle after done is accepted
    start_seq('0);
    check("restart_valid", rk_valid, 1'b1);
    check("restart_key0", round_key, 128'h0);
    wait_idle(50);
    check("restart_rk10", got_rk[10], Z_RK10);
    check("restart_done_cnt", done_cnt, 2);

    // reset in the middle of a sequence
    clear_counts();
    start_seq(KEY_A1);
    wait_index(4'd7, 20);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    check("mid_rst_valid", rk_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_index", rk_index, 4'd0);
    check("mid_rst_key", round_key, 128'h0);
    check("mid_rst_done", done, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_no_done", done_cnt, 0);
    clear_counts();
    start_seq(KEY_A1);
    wait_idle(50);
    check("post_rst_rk0", got_rk[0], KEY_A1);
    check("post_rst_rk1", got_rk[1], A1_RK1);
    check("post_rst_rk10", got_rk[10], A1_RK10);
    check("post_rst_done_cnt", done_cnt, 1);

    // random keys with random ready; monitor checks keys and rcon
    ready_mode = 1;
    for (int k = 0; k < 1000; k++) begin
      start_seq({$urandom, $urandom, $urandom, $urandom});
      wait_idle(400);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
